// File: rtl/fetch_predict_stage.sv
// Fetch stage: PC register, BHT direction predictor, zero-latency predecode.
// Optional JAL prediction is built when FETCH_JAL_PREDICT_EN is defined.
module fetch_predict_stage #(
    parameter int          BHT_IDX_BITS = 6,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        stg_clk,
    input  logic        reset,
    input  logic        stg_ena,
    input  logic        stg_x,
    input  logic [31:0] redirect_pc,
    input  logic        resolve_valid,
    input  logic [31:0] resolve_pc,
    input  logic        resolve_taken,
    input  logic [1:0]  resolve_counter,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out,
    output logic [1:0]  counter_out,
    output logic        branch_prediction_out
);

    localparam int         BHT_N     = 1 << BHT_IDX_BITS;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef FETCH_JAL_PREDICT_EN
    localparam logic [6:0] OP_JAL    = 7'b1101111;
`endif

    logic [31:0]             pc_q, pc_d;
    logic                    valid_q, valid_d;
    logic [1:0]              bht_q [BHT_N];
    logic [1:0]              bht_d [BHT_N];
    logic [BHT_IDX_BITS-1:0] rd_idx;
    logic [BHT_IDX_BITS-1:0] wr_idx;
    logic [1:0]              trained;
    logic                    is_branch;
    logic                    pred;
    logic [31:0]             b_imm;
    logic [31:0]             tgt_off;
    logic                    unused_resolve;

    assign rd_idx    = pc_q[BHT_IDX_BITS+1:2];
    assign wr_idx    = resolve_pc[BHT_IDX_BITS+1:2];
    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign instr_out = imem_rdata;
    assign valid_out = valid_q;
    assign counter_out           = bht_q[rd_idx];
    assign branch_prediction_out = pred;

    // Only the index bits of the resolved PC address the table.
    assign unused_resolve =
        ^{resolve_pc[31:BHT_IDX_BITS+2], resolve_pc[1:0]};

    // Predecode the fetched word and form the direction prediction.
    always_comb begin
        is_branch = (imem_rdata[6:0] == OP_BRANCH);
        b_imm     = {{20{imem_rdata[31]}}, imem_rdata[7],
                     imem_rdata[30:25], imem_rdata[11:8], 1'b0};
        pred      = is_branch & counter_out[1];
        tgt_off   = b_imm;
`ifdef FETCH_JAL_PREDICT_EN
        if (imem_rdata[6:0] == OP_JAL) begin
            pred    = 1'b1;
            tgt_off = {{12{imem_rdata[31]}}, imem_rdata[19:12],
                       imem_rdata[20], imem_rdata[30:21], 1'b0};
        end
`endif
    end

    // Next PC: redirect beats stall, stall beats prediction.
    always_comb begin
        pc_d    = pc_q + 32'd4;
        valid_d = 1'b1;
        if (stg_x) begin
            pc_d = redirect_pc;
        end else if (stg_ena) begin
            pc_d = pc_q;
        end else if (pred) begin
            pc_d = pc_q + tgt_off;
        end
    end

    // Saturating counter training from execute, independent of stalls.
    always_comb begin
        if (resolve_taken) begin
            trained = (resolve_counter == 2'd3) ? 2'd3
                                                : resolve_counter + 2'd1;
        end else begin
            trained = (resolve_counter == 2'd0) ? 2'd0
                                                : resolve_counter - 2'd1;
        end
        bht_d = bht_q;
        if (resolve_valid) begin
            bht_d[wr_idx] = trained;
        end
    end

    // State registers; BHT resets to weakly not-taken.
    always_ff @(posedge stg_clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            for (int i = 0; i < BHT_N; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            bht_q   <= bht_d;
        end
    end

endmodule

// File: tb/tb_fetch_predict_stage.sv
// Scoreboarded random/directed bench for fetch_predict_stage.
// The reference tracks the program as (kind, offset) per address.
module tb_fetch_predict_stage;

    logic        stg_clk = 1'b0;
    logic        reset = 1'b1;
    logic        stg_ena = 1'b0;
    logic        stg_x = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        resolve_valid = 1'b0;
    logic [31:0] resolve_pc = '0;
    logic        resolve_taken = 1'b0;
    logic [1:0]  resolve_counter = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0000_0013;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out;
    logic [1:0]  counter_out;
    logic        branch_prediction_out;

    fetch_predict_stage dut (
        .stg_clk(stg_clk),
        .reset(reset),
        .stg_ena(stg_ena),
        .stg_x(stg_x),
        .redirect_pc(redirect_pc),
        .resolve_valid(resolve_valid),
        .resolve_pc(resolve_pc),
        .resolve_taken(resolve_taken),
        .resolve_counter(resolve_counter),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .pc_out(pc_out),
        .instr_out(instr_out),
        .valid_out(valid_out),
        .counter_out(counter_out),
        .branch_prediction_out(branch_prediction_out)
    );

    always #5 stg_clk = ~stg_clk;

    // Program: 0 = NOP, 1 = conditional branch, 2 = JAL.
    int kind [logic [31:0]];
    int offs [logic [31:0]];

    // Reference state.
    logic [31:0] m_pc;
    bit          m_valid;
    int          m_bht [64];

    logic [67:0] exp_q [$];
    int total = 0;
    int bad = 0;
    int ncyc = 0;

    function automatic logic [31:0] enc_b(int off);
        logic [12:0] o;
        o = 13'(off);
        return {o[12], o[10:5], 5'd2, 5'd1, 3'b000,
                o[4:1], o[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(int off);
        logic [20:0] o;
        o = 21'(off);
        return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] word_at(logic [31:0] a);
        if (!kind.exists(a) || kind[a] == 0) return 32'h0000_0013;
        if (kind[a] == 1) return enc_b(offs[a]);
        return enc_j(offs[a]);
    endfunction

    function automatic int k_at(logic [31:0] a);
        return kind.exists(a) ? kind[a] : 0;
    endfunction

    function automatic int bidx(logic [31:0] a);
        return int'((a / 4) % 64);
    endfunction

    function automatic bit predict(logic [31:0] a);
        bit p;
        p = (k_at(a) == 1) && (m_bht[bidx(a)] >= 2);
`ifdef FETCH_JAL_PREDICT_EN
        if (k_at(a) == 2) p = 1'b1;
`endif
        return p;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        m_valid = 1'b0;
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
    endtask

    // One cycle: drive, push expectation, clock, advance reference.
    task automatic cyc(bit rst, bit x, bit ena, logic [31:0] rpc,
                       bit rv, logic [31:0] vpc, bit vt, int vc);
        bit p;
        reset = rst;
        stg_x = x;
        stg_ena = ena;
        redirect_pc = rpc;
        resolve_valid = rv;
        resolve_pc = vpc;
        resolve_taken = vt;
        resolve_counter = 2'(vc);
        if (rst) model_reset();
        #0;
        imem_rdata = word_at(imem_addr);
        p = predict(m_pc);
        exp_q.push_back({m_pc, word_at(m_pc), m_valid,
                         2'(m_bht[bidx(m_pc)]), p});
        @(posedge stg_clk);
        if (!rst) begin
            if (rv) begin
                if (vt) m_bht[bidx(vpc)] = (vc == 3) ? 3 : vc + 1;
                else    m_bht[bidx(vpc)] = (vc == 0) ? 0 : vc - 1;
            end
            if (x) m_pc = rpc;
            else if (ena) m_pc = m_pc;
            else if (p) m_pc = m_pc + 32'(offs[m_pc]);
            else m_pc = m_pc + 32'd4;
            m_valid = 1'b1;
        end
        #1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic go(logic [31:0] a);
        cyc(0, 1, 0, a, 0, 0, 0, 0);
    endtask

    // Monitor: compare every presented cycle against the scoreboard.
    always @(negedge stg_clk) begin
        logic [67:0] e;
        logic [67:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pc_out, instr_out, valid_out, counter_out,
                 branch_prediction_out};
            total++;
            ncyc++;
            if (a !== e || imem_addr !== e[67:36]) begin
                bad++;
                $display("FAIL cyc%0d pc/instr/v/cnt/pred got %h %h %b %0d %b addr %h want %h %h %b %0d %b",
                         ncyc, a[67:36], a[35:4], a[3], a[2:1], a[0],
                         imem_addr, e[67:36], e[35:4], e[3],
                         e[2:1], e[0]);
            end
        end
    end

    initial begin
        logic [31:0] a;
        model_reset();
        @(posedge stg_clk);
        #1;
        // Reset, then three sequential NOP fetches.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        run(4);

        // Branch at 0x10, +0x20: not taken, then trained to taken.
        kind[32'h10] = 1;
        offs[32'h10] = 32'h20;
        go(32'h10);
        cyc(0, 0, 0, 0, 1, 32'h10, 1, 1);
        run(1);
        go(32'h10);
        run(2);

        // Saturation at both ends.
        cyc(0, 0, 0, 0, 1, 32'h10, 1, 3);
        go(32'h10);
        run(1);
        kind[32'h20] = 1;
        offs[32'h20] = -16;
        cyc(0, 0, 0, 0, 1, 32'h20, 0, 0);
        go(32'h20);
        run(1);

        // Stall with training of the held entry.
        go(32'h10);
        cyc(0, 0, 1, 0, 1, 32'h10, 0, 2);
        cyc(0, 0, 1, 0, 1, 32'h10, 0, 1);
        cyc(0, 0, 1, 0, 1, 32'h10, 1, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        run(2);

        // Redirect beats stall; wrap at the top of memory.
        cyc(0, 1, 1, 32'h100, 0, 0, 0, 0);
        run(1);
        go(32'hFFFF_FFFC);
        run(2);

        // JAL at 0x40, +0x80.
        kind[32'h40] = 2;
        offs[32'h40] = 32'h80;
        go(32'h40);
        run(2);

        // Mid-run reset drops a concurrent training write.
        cyc(1, 0, 0, 0, 1, 32'h0, 1, 2);
        run(2);

        // Random program and random control.
        for (int i = 0; i < 128; i++) begin
            a = 32'(i * 4);
            case ($urandom_range(0, 5))
                0, 1: begin
                    kind[a] = 1;
                    offs[a] = 4 * ($urandom_range(0, 32) - 16);
                end
                2: begin
                    kind[a] = 2;
                    offs[a] = 4 * ($urandom_range(0, 64) - 32);
                end
                default: kind[a] = 0;
            endcase
        end
        for (int i = 0; i < 600; i++) begin
            bit x, ena, rv;
            x   = ($urandom_range(0, 9) == 0);
            ena = ($urandom_range(0, 4) == 0);
            rv  = ($urandom_range(0, 2) == 0);
            cyc(0, x, ena, 32'($urandom_range(0, 127) * 4), rv,
                (rv && $urandom_range(0, 1) == 1) ? m_pc
                    : 32'($urandom_range(0, 255) * 4),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++)
            @(negedge stg_clk);
        #1;
        if (exp_q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain left=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
